// File: rtl/voice_scheduler.sv
// Voice scheduler: time-shares one synchronous sample ROM among four drum voices,
// walking the active voices once per audio sample tick and latching one byte each.
module voice_scheduler #(
    parameter int OFF_W     = 13,
    parameter int VOICE_LEN = 6000,
    parameter int ROM_LAT   = 2,
    parameter int SR_DIV    = 6250
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             play_i,
    input  logic [3:0]       trig_i,
    output logic             rom_rd_o,
    output logic [OFF_W+1:0] rom_addr_o,
    input  logic [7:0]       rom_data_i,
    output logic [31:0]      voice_out_o,
    output logic [3:0]       active_o,
    output logic             sample_tick_o,
    output logic             frame_done_o,
    output logic [1:0]       dbg_state_o,
    output logic [1:0]       dbg_voice_o
);

    localparam int DIV_W = $clog2(SR_DIV);
    localparam int LAT_W = $clog2(ROM_LAT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SR_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ROM_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(VOICE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e           state_q;
    logic [1:0]       v_q;
    logic [LAT_W-1:0] wait_q;
    logic             pend_q;
    logic [3:0]       active_q;
    logic [OFF_W+1:0] addr_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [OFF_W-1:0] offset_q [4];
    logic [7:0]       vout_q   [4];
    logic             tick;
    logic             capture;

    // ROM port: rom_rd_o is a one-cycle strobe with no back-pressure; the ROM must
    // present the addressed byte on rom_data_i exactly ROM_LAT cycles after the strobe.
    assign rom_rd_o   = (state_q == SCAN) && active_q[v_q];
    assign rom_addr_o = rom_rd_o ? {v_q, offset_q[v_q]} : addr_q;

    assign tick          = play_i && (div_q == DIV_LAST);
    assign sample_tick_o = tick;
    assign frame_done_o  = (state_q == DONE);
    assign capture       = (state_q == WAIT) && (wait_q == LAT_ONE);
    assign voice_out_o   = {vout_q[3], vout_q[2], vout_q[1], vout_q[0]};
    assign active_o      = active_q;
    assign dbg_state_o   = state_q;
    assign dbg_voice_o   = v_q;

    always_comb begin
        div_d = '0;
        if (play_i && !tick) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q    <= '0;
            state_q  <= IDLE;
            v_q      <= '0;
            wait_q   <= '0;
            pend_q   <= 1'b0;
            active_q <= '0;
            addr_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                offset_q[i] <= '0;
                vout_q[i]   <= '0;
            end
        end else begin
            div_q <= div_d;
            if (rom_rd_o) begin
                addr_q <= {v_q, offset_q[v_q]};
            end
            if (!play_i) begin
                state_q  <= IDLE;
                v_q      <= '0;
                wait_q   <= '0;
                pend_q   <= 1'b0;
                active_q <= '0;
                for (int i = 0; i < 4; i++) begin
                    offset_q[i] <= '0;
                    vout_q[i]   <= '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (tick) begin
                            state_q <= SCAN;
                            v_q     <= '0;
                        end
                    end
                    SCAN: begin
                        if (active_q[v_q]) begin
                            wait_q  <= LAT_LOAD;
                            pend_q  <= trig_i[v_q];
                            state_q <= WAIT;
                        end else begin
                            vout_q[v_q] <= '0;
                            if (v_q == 2'd3) begin
                                state_q <= DONE;
                            end else begin
                                v_q <= v_q + 2'd1;
                            end
                        end
                    end
                    WAIT: begin
                        if (capture) begin
                            vout_q[v_q] <= rom_data_i;
                            // A retrigger seen since the read was issued already restarted
                            // the voice, so the stale read must not advance its offset.
                            if (!pend_q && !trig_i[v_q]) begin
                                if (offset_q[v_q] == LAST_OFF) begin
                                    offset_q[v_q] <= '0;
                                    active_q[v_q] <= 1'b0;
                                end else begin
                                    offset_q[v_q] <= offset_q[v_q] + OFF_W'(1);
                                end
                            end
                            if (v_q == 2'd3) begin
                                state_q <= DONE;
                            end else begin
                                v_q     <= v_q + 2'd1;
                                state_q <= SCAN;
                            end
                        end else begin
                            wait_q <= wait_q - LAT_W'(1);
                            if (trig_i[v_q]) begin
                                pend_q <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        v_q     <= '0;
                    end
                    default: state_q <= IDLE;
                endcase
                // Triggers override whatever the walk decided for that voice this cycle.
                for (int i = 0; i < 4; i++) begin
                    if (trig_i[i]) begin
                        active_q[i] <= 1'b1;
                        offset_q[i] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: directed phases plus randomized triggers, checked against
// a frame-level reference model of the voice walk.
module tb_voice_scheduler;
  localparam int OFF_W     = 13;
  localparam int VOICE_LEN = 4;
  localparam int ROM_LAT   = 2;
  localparam int SR_DIV    = 32;
  localparam int AW        = OFF_W + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          play = 1'b0;
  logic [3:0]    trig = 4'b0;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [31:0]   voice_out;
  logic [3:0]    active;
  logic          tick;
  logic          fdone;
  logic [1:0]    dbg_state;
  logic [1:0]    dbg_voice;

  voice_scheduler #(
    .OFF_W(OFF_W), .VOICE_LEN(VOICE_LEN), .ROM_LAT(ROM_LAT), .SR_DIV(SR_DIV)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .play_i(play), .trig_i(trig),
    .rom_rd_o(rom_rd), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .voice_out_o(voice_out), .active_o(active), .sample_tick_o(tick),
    .frame_done_o(fdone), .dbg_state_o(dbg_state), .dbg_voice_o(dbg_voice)
  );

  // clock / ROM model: returns addr[7:0] two cycles after the strobe, 0xEE otherwise
  always #5 clk = ~clk;

  logic       rv0 = 1'b0, rv1 = 1'b0;
  logic [7:0] rb0 = 8'h0, rb1 = 8'h0;
  always @(posedge clk) begin
    rv0 <= rom_rd;
    rb0 <= rom_addr[7:0];
    rv1 <= rv0;
    rb1 <= rb0;
  end
  assign rom_data = rv1 ? rb1 : 8'hEE;

  // reference model state
  int            m_off [4];
  logic [3:0]    m_act = 4'b0;
  logic [31:0]   m_vo = 32'b0;
  logic [AW-1:0] m_addr = '0;
  int            cyc = 0;
  int            exp_tick = 0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    trig = 4'b0;
  endtask

  task automatic apply_trig(input logic [3:0] bits);
    trig = bits;
    if (play) begin
      for (int v = 0; v < 4; v++) begin
        if (bits[v]) begin
          m_act[v] = 1'b1;
          m_off[v] = 0;
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " rom_rd"}, rom_rd, 1'b0);
    chk({tag, " frame_done"}, fdone, 1'b0);
    chk({tag, " voice_out"}, voice_out, m_vo);
    chk({tag, " active"}, active, m_act);
    chk({tag, " rom_addr"}, rom_addr, m_addr);
  endtask

  task automatic start_play();
    play = 1'b1;
    exp_tick = cyc + SR_DIV - 1;
  endtask

  task automatic wait_tick(input bit rnd);
    forever begin
      step();
      if (cyc >= exp_tick) break;
      chk("idle tick", tick, 1'b0);
      check_idle("idle");
      if (rnd && $urandom_range(0, 19) == 0) apply_trig(4'($urandom_range(1, 15)));
    end
    chk("sample_tick", tick, 1'b1);
    check_idle("tick");
    exp_tick = cyc + SR_DIV;
  endtask

  // Walks the frame that starts after the tick just seen; cap_v >= 0 retriggers that
  // voice in the very cycle its byte is captured.
  task automatic run_frame(input int cap_v);
    logic          e_rd  [32];
    logic          e_fd  [32];
    logic [AW-1:0] e_addr[32];
    logic [31:0]   e_vo  [32];
    logic [3:0]    e_act [32];
    int c, vis, len, cap_cyc;
    cap_cyc = -1;
    for (int k = 0; k < 32; k++) begin
      e_rd[k] = 1'b0; e_fd[k] = 1'b0; e_addr[k] = m_addr; e_vo[k] = m_vo; e_act[k] = m_act;
    end
    c = 1;
    for (int v = 0; v < 4; v++) begin
      if (m_act[v]) begin
        e_rd[c] = 1'b1;
        for (int k = c; k < 32; k++) e_addr[k] = {2'(v), OFF_W'(m_off[v])};
        vis = c + ROM_LAT + 1;
        for (int k = vis; k < 32; k++) e_vo[k][8*v +: 8] = 8'(m_off[v]);
        if (v == cap_v) begin
          cap_cyc = c + ROM_LAT;
          m_off[v] = 0;
        end else if (m_off[v] == VOICE_LEN - 1) begin
          m_off[v] = 0;
          m_act[v] = 1'b0;
          for (int k = vis; k < 32; k++) e_act[k][v] = 1'b0;
        end else begin
          m_off[v] = m_off[v] + 1;
        end
        c = c + ROM_LAT + 1;
      end else begin
        for (int k = c + 1; k < 32; k++) e_vo[k][8*v +: 8] = 8'h00;
        c = c + 1;
      end
    end
    e_fd[c] = 1'b1;
    len = c + 1;
    for (int r = 1; r <= len; r++) begin
      step();
      chk($sformatf("rom_rd r%0d", r), rom_rd, e_rd[r]);
      chk($sformatf("rom_addr r%0d", r), rom_addr, e_addr[r]);
      chk($sformatf("frame_done r%0d", r), fdone, e_fd[r]);
      chk($sformatf("voice_out r%0d", r), voice_out, e_vo[r]);
      chk($sformatf("active r%0d", r), active, e_act[r]);
      chk($sformatf("walk tick r%0d", r), tick, 1'b0);
      if (r == cap_cyc) trig = 4'(1 << cap_v);
    end
    m_vo = e_vo[len];
    m_addr = e_addr[len];
  endtask

  initial begin
    logic [AW-1:0] a0;
    for (int v = 0; v < 4; v++) m_off[v] = 0;

    // reset state
    step(); step();
    chk("reset voice_out", voice_out, 32'h0);
    chk("reset active", active, 4'h0);
    chk("reset rom_rd", rom_rd, 1'b0);
    chk("reset rom_addr", rom_addr, '0);
    chk("reset frame_done", fdone, 1'b0);
    chk("reset tick", tick, 1'b0);
    rst_n = 1'b1;

    // triggers ignored while stopped
    step();
    apply_trig(4'b1111);
    step(); step();
    chk("stopped active", active, 4'h0);

    // idle frame, then single voice over five ticks
    start_play();
    wait_tick(0);
    run_frame(-1);
    apply_trig(4'b0100);
    for (int f = 0; f < 5; f++) begin
      wait_tick(0);
      run_frame(-1);
    end
    chk("single voice_out[23:16] final", voice_out[23:16], 8'h00);
    chk("single active final", active, 4'b0000);

    // all voices, then retrigger voice 1 at its offset-2 capture
    apply_trig(4'b1111);
    wait_tick(0); run_frame(-1);
    wait_tick(0); run_frame(-1);
    wait_tick(0); run_frame(1);
    chk("retrig voice_out[15:8]", voice_out[15:8], 8'h02);
    chk("retrig active[1]", active[1], 1'b1);
    wait_tick(0); run_frame(-1);

    // randomized triggers and capture-cycle retriggers
    for (int f = 0; f < 30; f++) begin
      int cv;
      wait_tick(1);
      cv = $urandom_range(0, 5);
      if (cv < 4 && m_act[cv]) run_frame(cv);
      else run_frame(-1);
    end

    // play drop during WAIT of voice 0
    apply_trig(4'b1111);
    wait_tick(0);
    step();
    a0 = {2'b00, OFF_W'(m_off[0])};
    chk("drop rd issued", rom_rd, 1'b1);
    chk("drop rd addr", rom_addr, a0);
    step();
    play = 1'b0;
    m_act = 4'b0; m_vo = 32'b0; m_addr = a0;
    for (int v = 0; v < 4; v++) m_off[v] = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      check_idle("drop");
      chk("drop tick", tick, 1'b0);
      if (k % 2 == 0) apply_trig(4'($urandom_range(1, 15)));
    end
    start_play();
    wait_tick(0);
    run_frame(-1);

    // asynchronous reset mid-walk
    apply_trig(4'b0011);
    wait_tick(0);
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("async voice_out", voice_out, 32'h0);
    chk("async active", active, 4'h0);
    chk("async rom_rd", rom_rd, 1'b0);
    chk("async rom_addr", rom_addr, '0);
    chk("async frame_done", fdone, 1'b0);
    play = 1'b0;
    step(); step();
    rst_n = 1'b1;
    m_act = 4'b0; m_vo = 32'b0; m_addr = '0;
    for (int v = 0; v < 4; v++) m_off[v] = 0;
    start_play();
    wait_tick(0);
    run_frame(-1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
